// File: rtl/inst_axi_bridge.sv
// I-cache SRAM-like miss port to AXI read channel, one single-beat read outstanding; IBRIDGE_RESP_CHK_EN adds rd_err.
// Latency req->data_ok 3 cycles minimum, +1 per cycle of arready/rvalid low; addr_ok held off until the response retires.
module inst_axi_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef IBRIDGE_RESP_CHK_EN
    ,
    output logic        rd_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        data_ok_q;
`ifdef IBRIDGE_RESP_CHK_EN
    logic        rd_err_q;
`endif

    // Writes are never issued; rid/rlast carry no information with one single-beat read in flight.
    logic unused_ok;
    assign unused_ok = ^{wr, wdata, rid, rlast, rresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            araddr_q  <= 32'h0;
            arsize_q  <= 2'd0;
            rdata_q   <= 32'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
`ifdef IBRIDGE_RESP_CHK_EN
            rd_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        araddr_q  <= addr;
                        arsize_q  <= size;
                        arvalid_q <= 1'b1;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= rdata_axi;
                        data_ok_q <= 1'b1;
`ifdef IBRIDGE_RESP_CHK_EN
                        rd_err_q  <= rresp[1];
`endif
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    data_ok_q <= 1'b0;
`ifdef IBRIDGE_RESP_CHK_EN
                    rd_err_q  <= 1'b0;
`endif
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the request handshake is combinational; every AXI-derived output comes from a flop.
    assign addr_ok = req && (state_q == IDLE);
    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;
    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
`ifdef IBRIDGE_RESP_CHK_EN
    assign rd_err  = rd_err_q;
`endif

endmodule

// File: doc/inst_axi_bridge.md
# inst_axi_bridge

Read-only bridge from the instruction cache's SRAM-like miss port to an AXI master read channel. It takes one single-beat refill request at a time from the instruction cache, issues it as an AXI AR transaction, and returns the beat as a one-cycle `data_ok` pulse with registered data. It sits directly downstream of the instruction cache and upstream of the core's top-level AXI port or interconnect.

## Interface
- `ARID_VAL`, default 4'd0 — constant driven on `arid`; no other value is ever in flight.
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  1  SRAM-like request; held by cache until `addr_ok`
- `wr`  in  1  write flag; ignored, every request is a read
- `size`  in  2  transfer size (0=byte, 1=half, 2=word)
- `addr`  in  32  byte address
- `wdata`  in  32  ignored
- `rdata`  out  32  returned instruction word; valid while `data_ok`=1
- `addr_ok`  out  1  request accepted this cycle
- `data_ok`  out  1  one-cycle response pulse
- `arid`  out  4  = `ARID_VAL`
- `araddr`  out  32  latched `addr`
- `arlen`  out  8  constant 0 (single beat)
- `arsize`  out  3  {1'b0, latched `size`}
- `arburst`  out  2  constant 2'b01 (INCR)
- `arlock`  out  2  constant 0
- `arcache`  out  4  constant 0
- `arprot`  out  3  constant 0
- `arvalid`  out  1  AR valid
- `arready`  in  1  AR ready
- `rid`  in  4  ignored (single outstanding)
- `rdata_axi`  in  32  R data
- `rresp`  in  2  R response
- `rlast`  in  1  ignored (arlen=0, first beat is last)
- `rvalid`  in  1  R valid
- `rready`  out  1  R ready
- The AW/W/B channels are not part of this block.

## Operation
- FSM states: IDLE, AR, R, RESP.
- IDLE: `addr_ok` = `req` (combinational). On `req`=1: latch `addr` and `size`; next state AR.
- AR: `arvalid`=1 with the latched address and size. On `arready`=1: next state R. `arvalid` stays high and the AR outputs stay stable until the handshake completes.
- R: `rready`=1. On `rvalid`=1: capture `rdata_axi` into the `rdata` register (and `rresp` when the macro is set); next state RESP.
- RESP: `data_ok`=1 for exactly one cycle; next state IDLE.
- `addr_ok` is 0 outside IDLE, so at most one transaction is outstanding.
- `wr`=1 is accepted and handled as a read.
- `rdata` holds its last captured value until the next capture.

## Timing
- Reset values: state IDLE; `arvalid`, `rready`, `data_ok` = 0; `rdata` and latched `araddr`/`arsize` = 0. `addr_ok` follows `req` in the first cycle after reset.
- Minimum latency, with `arready` and `rvalid` both high as early as possible:
  - cycle 0: IDLE, `addr_ok`.
  - cycle 1: AR, `arvalid`+`arready`.
  - cycle 2: R, `rvalid`+`rready`.
  - cycle 3: RESP, `data_ok`.
- Back-to-back throughput: 1 request per 4 cycles. A new `req` is first accepted in the cycle after RESP.
- Each cycle `arready` or `rvalid` is held low adds one cycle in AR or R respectively; there is no timeout.
- `rvalid` while in IDLE, AR or RESP is ignored, and `rready` is 0 in those states.
- `rst` asserted in any state: the next state is IDLE and all outputs take their reset values. An in-flight AXI transaction is not drained, because system reset also resets the interconnect.
- No combinational path exists from any AXI input to any SRAM-like output. `addr_ok` depends only on `req` and the state.

## Configuration
- `IBRIDGE_RESP_CHK_EN` defined:
  - Adds output port `rd_err` (out, 1).
  - `rd_err` = `data_ok` & captured `rresp[1]`, i.e. high for SLVERR or DECERR.
  - The data is still returned.
  - Reset value of `rd_err` is 0.
- Not defined: `rresp` is unused, and the `rd_err` port and its register do not exist.

## Test plan
- Single read: `req`=1, `addr`=0xBFC0_0000, `size`=2. `arready` held 1; `rvalid` returned the cycle after the AR handshake with data 0x2408_0001. Required: `addr_ok` in cycle 0, `araddr`=0xBFC0_0000, `arsize`=3'b010, `arlen`=0, `data_ok` in cycle 3 with `rdata`=0x2408_0001.
- Backpressure: `arready` low for 3 cycles, then `rvalid` delayed 5 cycles after the AR handshake. Required: `arvalid` and `araddr` stable throughout, exactly one `data_ok`, total latency 3+3+5 = 11 cycles.
- Back-to-back: `req` held high across two addresses, 0x0000_1000 and 0x0000_1004. Required: second `addr_ok` exactly 4 cycles after the first, two `data_ok` pulses, correct data order.
- Reset mid-operation: assert `rst` for 1 cycle while in state R. Required: next cycle `rready`=0 and `data_ok`=0, state IDLE, and a fresh request then completes normally.
- Spurious beat: `rvalid`=1 with data 0xDEAD_BEEF while in IDLE. Required: `rready`=0, `rdata` unchanged, no `data_ok`.
- `IBRIDGE_RESP_CHK_EN` set, `rresp`=2'b10. Required: `rd_err`=1 exactly in the `data_ok` cycle. With `rresp`=2'b00, `rd_err` stays 0.
